l1_dcache: RTL

- Direct-mapped, write-back, write-allocate L1 data cache between the CPU memory stage and l1mmu.
- Initiator of the l1mmu request/done protocol: issues 256-bit line refills and write-backs, plus uncached single-word accesses for the MMIO window.
- CPU side is a simple hold-until-ready word interface.

---
 rtl/l1_dcache.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
// Sits between the CPU memory stage (hold-until-ready word interface) and
// l1mmu (request/done protocol, 256-bit lines). Accesses whose addr[31:16]
// equals MMIO_PREFIX bypass the cache as single-word uncached transfers.
// Optional feature macro: L1_DCACHE_STATS_EN adds hit/miss counters.

module l1_dcache #(
    parameter int          INDEX_BITS  = 6,
    parameter logic [15:0] MMIO_PREFIX = 16'hFFFF
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    input  logic         cpu_req_read,
    input  logic         cpu_req_write,
    input  logic [31:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic [3:0]   cpu_wstrb,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         l1_mmu_req_read,
    output logic         l1_mmu_req_write,
    output logic [31:0]  l1_mmu_req_addr,
    output logic [255:0] l1_mmu_write_data,
    input  logic         mmu_l1_done,
    input  logic [255:0] mmu_l1_read_data
`ifdef L1_DCACHE_STATS_EN
    ,
    output logic [31:0]  stat_hits,
    output logic [31:0]  stat_misses
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - 5 - INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_REFILL,
        S_MMIO,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // Set on write-back completion so the refill request starts one cycle
    // later, leaving l1mmu a request-low cycle to return to idle.
    logic gap_q, gap_d;

    logic [31:0] mmio_rdata_q;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [255:0]        data_q [LINES];

    // Address decomposition of the held CPU request.
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag_in;
    logic [2:0]            off;
    assign idx    = cpu_addr[5+INDEX_BITS-1:5];
    assign tag_in = cpu_addr[31:5+INDEX_BITS];
    assign off    = cpu_addr[4:2];

    // Byte lane within the word is irrelevant: all accesses are word-sized.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    logic         req_any;
    logic         is_mmio;
    logic         tag_match;
    logic [255:0] line_rd;
    logic [31:0]  word_rd;
    logic [255:0] merged_line;

    assign req_any   = cpu_req_read | cpu_req_write;
    assign is_mmio   = (cpu_addr[31:16] == MMIO_PREFIX);
    assign tag_match = valid_q[idx] && (tag_q[idx] == tag_in);
    assign line_rd   = data_q[idx];
    assign word_rd   = line_rd[{off, 5'b00000} +: 32];

    // Store data merged into the addressed word under the byte enables.
    always_comb begin
        merged_line = line_rd;
        for (int b = 0; b < 4; b++) begin
            if (cpu_wstrb[b]) begin
                merged_line[{off, b[1:0], 3'b000} +: 8] = cpu_wdata[b*8 +: 8];
            end
        end
    end

    logic store_hit;
    logic load_store_hit;
    logic miss_start;
    logic wb_done;
    logic refill_done;
    logic mmio_done;

    // Next-state logic and all CPU/l1mmu outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned and infers a latch.
        state_d           = state_q;
        gap_d             = 1'b0;
        cpu_ready         = 1'b0;
        cpu_rdata         = mmio_rdata_q;
        l1_mmu_req_read   = 1'b0;
        l1_mmu_req_write  = 1'b0;
        l1_mmu_req_addr   = 32'd0;
        l1_mmu_write_data = 256'd0;
        store_hit         = 1'b0;
        load_store_hit    = 1'b0;
        miss_start        = 1'b0;
        wb_done           = 1'b0;
        refill_done       = 1'b0;
        mmio_done         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (is_mmio) begin
                        state_d = S_MMIO;
                    end else if (tag_match) begin
                        cpu_ready      = 1'b1;
                        cpu_rdata      = word_rd;
                        load_store_hit = 1'b1;
                        store_hit      = cpu_req_write;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_REFILL;
                    end
                end
            end
            S_WB: begin
                l1_mmu_req_write  = 1'b1;
                l1_mmu_req_addr   = {tag_q[idx], idx, 5'b00000};
                l1_mmu_write_data = line_rd;
                if (mmu_l1_done) begin
                    wb_done = 1'b1;
                    gap_d   = 1'b1;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (!gap_q) begin
                    l1_mmu_req_read = 1'b1;
                    l1_mmu_req_addr = {tag_in, idx, 5'b00000};
                    if (mmu_l1_done) begin
                        refill_done = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_MMIO: begin
                l1_mmu_req_write  = cpu_req_write;
                l1_mmu_req_read   = !cpu_req_write;
                l1_mmu_req_addr   = {cpu_addr[31:2], 2'b00};
                l1_mmu_write_data = {224'd0, cpu_wdata};
                if (mmu_l1_done) begin
                    mmio_done = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and control flags; reset drops any in-flight request.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gap_q        <= 1'b0;
            mmio_rdata_q <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            gap_q   <= gap_d;
            if (mmio_done) begin
                mmio_rdata_q <= mmu_l1_read_data[31:0];
            end
        end
    end

    // Per-line valid/dirty bits: cleared by reset, updated by refill, write-back and store hits.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (refill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (wb_done) begin
                dirty_q[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: filled on refill, merged on store hits.
    // NOTE: the arrays have no reset; contents are meaningless until the valid bit is set.
    always_ff @(posedge sys_clk) begin
        if (refill_done) begin
            data_q[idx] <= mmu_l1_read_data;
            tag_q[idx]  <= tag_in;
        end else if (store_hit) begin
            data_q[idx] <= merged_line;
        end
    end

`ifdef L1_DCACHE_STATS_EN
    // Hit/miss counters; a hit that completes a refill is not a true hit.
    logic        refilled_q;
    logic [31:0] stat_hits_q;
    logic [31:0] stat_misses_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            refilled_q    <= 1'b0;
            stat_hits_q   <= 32'd0;
            stat_misses_q <= 32'd0;
        end else begin
            if (refill_done) begin
                refilled_q <= 1'b1;
            end else if (load_store_hit) begin
                refilled_q <= 1'b0;
            end
            if (load_store_hit && !refilled_q) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (miss_start) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`else
    logic unused_stat_events;
    assign unused_stat_events = load_store_hit ^ miss_start;
`endif

endmodule
